// File: rtl/execution_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execution_stage_pkg
// Description : ALU operation codes, load/store type encodings and the EX/MEM
//               pipeline register bundle shared by the execution stage.
// Revision    : 1.0 - initial release
// ============================================================================
package execution_stage_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // ALU operation codes
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_BEQ  = 5'd12;
  localparam logic [4:0] ALU_BNE  = 5'd13;
  localparam logic [4:0] ALU_BLT  = 5'd14;
  localparam logic [4:0] ALU_BGE  = 5'd15;
  localparam logic [4:0] ALU_BLTU = 5'd16;
  localparam logic [4:0] ALU_BGEU = 5'd17;
  localparam logic [4:0] ALU_JAL  = 5'd18;
  localparam logic [4:0] ALU_JALR = 5'd19;

  // Load types (0 means the instruction is not a load)
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  // Store types (0 means the instruction is not a store)
  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  // Contents of the EX/MEM pipeline register
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd_address;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] store_data;
    logic        wb_mux_select;
    logic        rd_write_enable;
  } ex_mem_t;

endpackage
`default_nettype wire

// File: rtl/execution_stage_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_unit
// Description : Selects one source operand from EX/MEM, WB or the register
//               file. Register x0 always reads as zero; EX/MEM wins over WB.
//               A load sitting in EX/MEM has no data yet, so it never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_unit
  import execution_stage_pkg::*;
(
  input  logic [4:0]  i_rs_address,
  input  logic [31:0] i_rf_data,
  input  logic        i_exmem_write_enable,
  input  logic [4:0]  i_exmem_rd_address,
  input  logic        i_exmem_is_load,
  input  logic [31:0] i_exmem_result,
  input  logic        i_wb_write_enable,
  input  logic [4:0]  i_wb_rd_address,
  input  logic [31:0] i_wb_rd_data,
  output logic [31:0] o_operand
);

  // Priority select: x0, then the younger EX/MEM result, then WB, then regfile
  always_comb begin
    o_operand = i_rf_data;
    if (i_rs_address == 5'd0) begin
      o_operand = '0;
    end else if ((i_exmem_write_enable == HIGH) && (i_exmem_rd_address == i_rs_address)
                 && (i_exmem_is_load == LOW)) begin
      o_operand = i_exmem_result;
    end else if ((i_wb_write_enable == HIGH) && (i_wb_rd_address == i_rs_address)) begin
      o_operand = i_wb_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execution_stage.sv
`default_nettype none
// ============================================================================
// Module      : execution_stage
// Description : Pipeline EX stage. Forwards operands, executes the ALU
//               operation, resolves branches/jumps, detects load-use hazards
//               and registers the results into EX/MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module execution_stage
  import execution_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_EXECUTION_STAGE,
  input  logic        CLEAR_EXECUTION_STAGE,
  input  logic [31:0] PC_IN,
  input  logic [4:0]  RS1_ADDRESS,
  input  logic [4:0]  RS2_ADDRESS,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] IMM_INPUT,
  input  logic [4:0]  SHIFT_AMOUNT,
  input  logic [4:0]  ALU_INSTRUCTION,
  input  logic        ALU_INPUT_1_SELECT,
  input  logic        ALU_INPUT_2_SELECT,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  input  logic [4:0]  WB_RD_ADDRESS,
  input  logic [31:0] WB_RD_DATA,
  input  logic        WB_RD_WRITE_ENABLE,
  output logic        BRANCH_TAKEN,
  output logic [31:0] BRANCH_TARGET,
  output logic        LOAD_USE_STALL,
  output logic [31:0] ALU_RESULT,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [2:0]  DATA_CACHE_LOAD_OUT,
  output logic [1:0]  DATA_CACHE_STORE_OUT,
  output logic [31:0] DATA_CACHE_STORE_DATA,
  output logic        WRITE_BACK_MUX_SELECT_OUT,
  output logic        RD_WRITE_ENABLE_OUT
);

  ex_mem_t     ex_mem_q;
  ex_mem_t     ex_mem_d;

  logic        w_exmem_is_load;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic        w_branch_cond;
  logic [31:0] w_branch_target;
  logic        w_load_use_stall;

  assign w_exmem_is_load = (ex_mem_q.load_type != LOAD_NONE);

  forwarding_unit u_fwd_rs1 (
    .i_rs_address         (RS1_ADDRESS),
    .i_rf_data            (RS1_DATA),
    .i_exmem_write_enable (ex_mem_q.rd_write_enable),
    .i_exmem_rd_address   (ex_mem_q.rd_address),
    .i_exmem_is_load      (w_exmem_is_load),
    .i_exmem_result       (ex_mem_q.alu_result),
    .i_wb_write_enable    (WB_RD_WRITE_ENABLE),
    .i_wb_rd_address      (WB_RD_ADDRESS),
    .i_wb_rd_data         (WB_RD_DATA),
    .o_operand            (w_rs1_fwd)
  );

  forwarding_unit u_fwd_rs2 (
    .i_rs_address         (RS2_ADDRESS),
    .i_rf_data            (RS2_DATA),
    .i_exmem_write_enable (ex_mem_q.rd_write_enable),
    .i_exmem_rd_address   (ex_mem_q.rd_address),
    .i_exmem_is_load      (w_exmem_is_load),
    .i_exmem_result       (ex_mem_q.alu_result),
    .i_wb_write_enable    (WB_RD_WRITE_ENABLE),
    .i_wb_rd_address      (WB_RD_ADDRESS),
    .i_wb_rd_data         (WB_RD_DATA),
    .o_operand            (w_rs2_fwd)
  );

  // A load in EX/MEM whose destination is read here cannot be forwarded yet.
  // Both sources are checked even if the instruction ignores rs2.
  assign w_load_use_stall = w_exmem_is_load && (ex_mem_q.rd_write_enable == HIGH)
                            && (ex_mem_q.rd_address != 5'd0)
                            && ((ex_mem_q.rd_address == RS1_ADDRESS)
                                || (ex_mem_q.rd_address == RS2_ADDRESS));

  // Operand and shift-count selection
  assign w_op_a  = ALU_INPUT_1_SELECT ? PC_IN : w_rs1_fwd;
  assign w_op_b  = ALU_INPUT_2_SELECT ? IMM_INPUT : w_rs2_fwd;
  assign w_shamt = ALU_INPUT_2_SELECT ? SHIFT_AMOUNT : w_op_b[4:0];

  // ALU datapath and branch/jump resolution
  always_comb begin
    w_alu_result    = '0;
    w_branch_cond   = LOW;
    w_branch_target = PC_IN + IMM_INPUT;
    case (ALU_INSTRUCTION)
      ALU_ADD:  w_alu_result = w_op_a + w_op_b;
      ALU_SUB:  w_alu_result = w_op_a - w_op_b;
      ALU_SLL:  w_alu_result = w_op_a << w_shamt;
      ALU_SLT:  w_alu_result = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: w_alu_result = {31'd0, (w_op_a < w_op_b)};
      ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu_result = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
      ALU_OR:   w_alu_result = w_op_a | w_op_b;
      ALU_AND:  w_alu_result = w_op_a & w_op_b;
      ALU_LUI:  w_alu_result = IMM_INPUT;
      ALU_BEQ:  w_branch_cond = (w_rs1_fwd == w_rs2_fwd);
      ALU_BNE:  w_branch_cond = (w_rs1_fwd != w_rs2_fwd);
      ALU_BLT:  w_branch_cond = ($signed(w_rs1_fwd) < $signed(w_rs2_fwd));
      ALU_BGE:  w_branch_cond = ($signed(w_rs1_fwd) >= $signed(w_rs2_fwd));
      ALU_BLTU: w_branch_cond = (w_rs1_fwd < w_rs2_fwd);
      ALU_BGEU: w_branch_cond = (w_rs1_fwd >= w_rs2_fwd);
      ALU_JAL: begin
        w_branch_cond = HIGH;
        w_alu_result  = PC_IN + 32'd4;
      end
      ALU_JALR: begin
        w_branch_cond   = HIGH;
        w_branch_target = (w_rs1_fwd + IMM_INPUT) & 32'hFFFF_FFFE;
        w_alu_result    = PC_IN + 32'd4;
      end
      default: ;
    endcase
  end

  // A redirect only fires in the cycle the instruction actually advances
  assign BRANCH_TAKEN   = w_branch_cond && !STALL_EXECUTION_STAGE && !w_load_use_stall && !RST;
  assign BRANCH_TARGET  = w_branch_target;
  assign LOAD_USE_STALL = w_load_use_stall;

  // EX/MEM next value: clear > hold > bubble > capture
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (CLEAR_EXECUTION_STAGE) begin
      ex_mem_d = '0;
    end else if (STALL_EXECUTION_STAGE) begin
      ex_mem_d = ex_mem_q;
    end else if (w_load_use_stall) begin
      ex_mem_d = '0;
    end else begin
      ex_mem_d.alu_result      = w_alu_result;
      ex_mem_d.rd_address      = RD_ADDRESS_IN;
      ex_mem_d.load_type       = DATA_CACHE_LOAD_IN;
      ex_mem_d.store_type      = DATA_CACHE_STORE_IN;
      ex_mem_d.store_data      = w_rs2_fwd;
      ex_mem_d.wb_mux_select   = WRITE_BACK_MUX_SELECT_IN;
      ex_mem_d.rd_write_enable = RD_WRITE_ENABLE_IN;
    end
  end

  // EX/MEM register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ALU_RESULT                = ex_mem_q.alu_result;
  assign RD_ADDRESS_OUT            = ex_mem_q.rd_address;
  assign DATA_CACHE_LOAD_OUT       = ex_mem_q.load_type;
  assign DATA_CACHE_STORE_OUT      = ex_mem_q.store_type;
  assign DATA_CACHE_STORE_DATA     = ex_mem_q.store_data;
  assign WRITE_BACK_MUX_SELECT_OUT = ex_mem_q.wb_mux_select;
  assign RD_WRITE_ENABLE_OUT       = ex_mem_q.rd_write_enable;

endmodule
`default_nettype wire

// File: tb/tb_execution_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execution_stage
// Description : Self-checking bench for execution_stage: behavioural model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execution_stage;

  logic        CLK = 1'b0;
  logic        RST, STALL_EXECUTION_STAGE, CLEAR_EXECUTION_STAGE;
  logic [31:0] PC_IN, RS1_DATA, RS2_DATA, IMM_INPUT, WB_RD_DATA;
  logic [4:0]  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_IN, SHIFT_AMOUNT, ALU_INSTRUCTION, WB_RD_ADDRESS;
  logic        ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, WRITE_BACK_MUX_SELECT_IN;
  logic        RD_WRITE_ENABLE_IN, WB_RD_WRITE_ENABLE;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic        BRANCH_TAKEN, LOAD_USE_STALL, WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT;
  logic [31:0] BRANCH_TARGET, ALU_RESULT, DATA_CACHE_STORE_DATA;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [2:0]  DATA_CACHE_LOAD_OUT;
  logic [1:0]  DATA_CACHE_STORE_OUT;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  execution_stage dut (
    .CLK(CLK), .RST(RST),
    .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE), .CLEAR_EXECUTION_STAGE(CLEAR_EXECUTION_STAGE),
    .PC_IN(PC_IN), .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .IMM_INPUT(IMM_INPUT), .SHIFT_AMOUNT(SHIFT_AMOUNT), .ALU_INSTRUCTION(ALU_INSTRUCTION),
    .ALU_INPUT_1_SELECT(ALU_INPUT_1_SELECT), .ALU_INPUT_2_SELECT(ALU_INPUT_2_SELECT),
    .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .WB_RD_ADDRESS(WB_RD_ADDRESS), .WB_RD_DATA(WB_RD_DATA), .WB_RD_WRITE_ENABLE(WB_RD_WRITE_ENABLE),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET), .LOAD_USE_STALL(LOAD_USE_STALL),
    .ALU_RESULT(ALU_RESULT), .RD_ADDRESS_OUT(RD_ADDRESS_OUT),
    .DATA_CACHE_LOAD_OUT(DATA_CACHE_LOAD_OUT), .DATA_CACHE_STORE_OUT(DATA_CACHE_STORE_OUT),
    .DATA_CACHE_STORE_DATA(DATA_CACHE_STORE_DATA),
    .WRITE_BACK_MUX_SELECT_OUT(WRITE_BACK_MUX_SELECT_OUT), .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT)
  );

  // ---------------- behavioural model ----------------
  // Expected EX/MEM contents
  logic [31:0] m_res, m_sdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_load;
  logic [1:0]  m_store;
  logic        m_wbsel, m_we;

  initial begin
    m_res = 0; m_sdata = 0; m_rd = 0; m_load = 0; m_store = 0; m_wbsel = 0; m_we = 0;
  end

  function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (m_we && m_rd == a && m_load == 0) return m_res;
    if (WB_RD_WRITE_ENABLE && WB_RD_ADDRESS == a) return WB_RD_DATA;
    return rf;
  endfunction

  function automatic logic m_lus();
    return (m_load != 0) && m_we && (m_rd != 0) && (m_rd == RS1_ADDRESS || m_rd == RS2_ADDRESS);
  endfunction

  // Result, redirect condition and target for the instruction currently presented
  function automatic void model_ex(output logic [31:0] res, output logic cond, output logic [31:0] tgt);
    logic [31:0] r1, r2, a, b;
    int          sh;
    r1 = mfwd(RS1_ADDRESS, RS1_DATA);
    r2 = mfwd(RS2_ADDRESS, RS2_DATA);
    a  = ALU_INPUT_1_SELECT ? PC_IN : r1;
    b  = ALU_INPUT_2_SELECT ? IMM_INPUT : r2;
    sh = ALU_INPUT_2_SELECT ? int'(SHIFT_AMOUNT) : int'(b % 32);
    res = 0; cond = 0; tgt = PC_IN + IMM_INPUT;
    case (int'(ALU_INSTRUCTION))
      1:  res = a + b;
      2:  res = a - b;
      3:  res = a << sh;
      4:  res = (int'(a) < int'(b)) ? 1 : 0;
      5:  res = (a < b) ? 1 : 0;
      6:  res = a ^ b;
      7:  res = a >> sh;
      8:  res = 32'(int'(a) >>> sh);
      9:  res = a | b;
      10: res = a & b;
      11: res = IMM_INPUT;
      12: cond = (r1 == r2);
      13: cond = (r1 != r2);
      14: cond = (int'(r1) < int'(r2));
      15: cond = (int'(r1) >= int'(r2));
      16: cond = (r1 < r2);
      17: cond = (r1 >= r2);
      18: begin cond = 1; res = PC_IN + 4; end
      19: begin cond = 1; res = PC_IN + 4; tgt = {r1[31:1] + IMM_INPUT[31:1] + 31'(r1[0] & IMM_INPUT[0]), 1'b0}; end
      default: ;
    endcase
  endfunction

  // Model register update
  always @(posedge CLK) begin
    logic [31:0] res, tgt;
    logic        cond;
    model_ex(res, cond, tgt);
    if (RST || CLEAR_EXECUTION_STAGE) begin
      m_res <= 0; m_sdata <= 0; m_rd <= 0; m_load <= 0; m_store <= 0; m_wbsel <= 0; m_we <= 0;
    end else if (STALL_EXECUTION_STAGE) begin
      // hold
    end else if (m_lus()) begin
      m_res <= 0; m_sdata <= 0; m_rd <= 0; m_load <= 0; m_store <= 0; m_wbsel <= 0; m_we <= 0;
    end else begin
      m_res <= res; m_rd <= RD_ADDRESS_IN; m_load <= DATA_CACHE_LOAD_IN;
      m_store <= DATA_CACHE_STORE_IN; m_sdata <= mfwd(RS2_ADDRESS, RS2_DATA);
      m_wbsel <= WRITE_BACK_MUX_SELECT_IN; m_we <= RD_WRITE_ENABLE_IN;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    logic [31:0] res, tgt;
    logic        cond, e_taken;
    if (chk_en) begin
      model_ex(res, cond, tgt);
      e_taken = cond && !STALL_EXECUTION_STAGE && !m_lus() && !RST;
      chk("branch_taken", 32'(BRANCH_TAKEN), 32'(e_taken));
      if (e_taken) chk("branch_target", BRANCH_TARGET, tgt);
      chk("load_use_stall", 32'(LOAD_USE_STALL), 32'(m_lus()));
      chk("alu_result", ALU_RESULT, m_res);
      chk("rd_address_out", 32'(RD_ADDRESS_OUT), 32'(m_rd));
      chk("load_out", 32'(DATA_CACHE_LOAD_OUT), 32'(m_load));
      chk("store_out", 32'(DATA_CACHE_STORE_OUT), 32'(m_store));
      chk("store_data", DATA_CACHE_STORE_DATA, m_sdata);
      chk("wb_sel_out", 32'(WRITE_BACK_MUX_SELECT_OUT), 32'(m_wbsel));
      chk("rd_we_out", 32'(RD_WRITE_ENABLE_OUT), 32'(m_we));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    STALL_EXECUTION_STAGE = 0; CLEAR_EXECUTION_STAGE = 0;
    PC_IN = 0; RS1_ADDRESS = 0; RS2_ADDRESS = 0; RD_ADDRESS_IN = 0;
    RS1_DATA = 0; RS2_DATA = 0; IMM_INPUT = 0; SHIFT_AMOUNT = 0; ALU_INSTRUCTION = 0;
    ALU_INPUT_1_SELECT = 0; ALU_INPUT_2_SELECT = 0; DATA_CACHE_LOAD_IN = 0; DATA_CACHE_STORE_IN = 0;
    WRITE_BACK_MUX_SELECT_IN = 0; RD_WRITE_ENABLE_IN = 0;
    WB_RD_ADDRESS = 0; WB_RD_DATA = 0; WB_RD_WRITE_ENABLE = 0;
  endtask

  task automatic instr(input logic [4:0] op, input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rs2a, input logic [31:0] rs2d, input logic sel2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic we,
                       input logic [31:0] pc);
    ALU_INSTRUCTION = op; RS1_ADDRESS = rs1a; RS1_DATA = rs1d; RS2_ADDRESS = rs2a; RS2_DATA = rs2d;
    ALU_INPUT_2_SELECT = sel2; IMM_INPUT = imm; RD_ADDRESS_IN = rd; RD_WRITE_ENABLE_IN = we; PC_IN = pc;
    ALU_INPUT_1_SELECT = 0; DATA_CACHE_LOAD_IN = 0; WRITE_BACK_MUX_SELECT_IN = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    step(); step();
    chk_en = 1;
    chk("reset_alu_result", ALU_RESULT, 32'd0);
    chk("reset_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    RST = 0;

    // ADD x1 = 5 + 7
    instr(5'd1, 5'd10, 32'd5, 5'd0, 32'd0, 1, 32'd7, 5'd1, 1, 32'h0);
    step(); chk("add_5_7", ALU_RESULT, 32'd12);
    // SUB x2 = x1 - 2, x1 from EX/MEM
    instr(5'd2, 5'd1, 32'hDEAD, 5'd0, 32'd0, 1, 32'd2, 5'd2, 1, 32'h0);
    step(); chk("sub_exmem_fwd", ALU_RESULT, 32'd10);
    // ADD x4 = x1 + x2, x1 from WB, x2 from EX/MEM
    instr(5'd1, 5'd1, 32'hBEEF, 5'd2, 32'hCAFE, 0, 32'd0, 5'd4, 1, 32'h0);
    WB_RD_ADDRESS = 1; WB_RD_DATA = 12; WB_RD_WRITE_ENABLE = 1;
    step(); chk("add_wb_and_exmem_fwd", ALU_RESULT, 32'd22);
    // Load x3
    WB_RD_WRITE_ENABLE = 0;
    instr(5'd1, 5'd0, 32'd0, 5'd0, 32'd0, 1, 32'h100, 5'd3, 1, 32'h0);
    DATA_CACHE_LOAD_IN = 3'd3; WRITE_BACK_MUX_SELECT_IN = 1;
    step(); chk("load_addr", ALU_RESULT, 32'h100);
    // Dependent ADD x5 = x3 + 0x10
    instr(5'd1, 5'd3, 32'h1234, 5'd0, 32'd0, 1, 32'h10, 5'd5, 1, 32'h0);
    #2 chk("load_use_stall_set", 32'(LOAD_USE_STALL), 32'd1);
    step();
    chk("bubble_result", ALU_RESULT, 32'd0);
    chk("bubble_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("stall_one_cycle", 32'(LOAD_USE_STALL), 32'd0);
    WB_RD_ADDRESS = 3; WB_RD_DATA = 32'h55; WB_RD_WRITE_ENABLE = 1;
    step(); chk("load_use_wb_fwd", ALU_RESULT, 32'h65);
    WB_RD_WRITE_ENABLE = 0;
    // BEQ taken
    instr(5'd12, 5'd6, 32'd9, 5'd7, 32'd9, 0, 32'h20, 5'd0, 0, 32'h100);
    #2 chk("beq_taken", 32'(BRANCH_TAKEN), 32'd1);
    chk("beq_target", BRANCH_TARGET, 32'h120);
    step();
    // BNE not taken
    instr(5'd13, 5'd6, 32'd9, 5'd7, 32'd9, 0, 32'h20, 5'd0, 0, 32'h100);
    #2 chk("bne_not_taken", 32'(BRANCH_TAKEN), 32'd0);
    step();
    // JALR
    instr(5'd19, 5'd8, 32'h203, 5'd0, 32'd0, 1, 32'd2, 5'd1, 1, 32'h40);
    #2 chk("jalr_taken", 32'(BRANCH_TAKEN), 32'd1);
    chk("jalr_target", BRANCH_TARGET, 32'h204);
    step(); chk("jalr_link", ALU_RESULT, 32'h44);
    // JAL while stalled: no redirect, outputs hold
    instr(5'd18, 5'd0, 32'd0, 5'd0, 32'd0, 1, 32'h10, 5'd1, 1, 32'h80);
    STALL_EXECUTION_STAGE = 1;
    #2 chk("stalled_jal_no_redirect", 32'(BRANCH_TAKEN), 32'd0);
    step(); chk("stall_hold", ALU_RESULT, 32'h44);
    // CLEAR and STALL together
    CLEAR_EXECUTION_STAGE = 1;
    step(); chk("clear_over_stall", ALU_RESULT, 32'd0);
    chk("clear_rd_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    CLEAR_EXECUTION_STAGE = 0; STALL_EXECUTION_STAGE = 0;
    instr(5'd1, 5'd10, 32'd5, 5'd0, 32'd0, 1, 32'd7, 5'd1, 1, 32'h0);
    step(); chk("add_again", ALU_RESULT, 32'd12);
    // RST during stall
    STALL_EXECUTION_STAGE = 1; RST = 1;
    step(); chk("reset_during_stall", ALU_RESULT, 32'd0);
    STALL_EXECUTION_STAGE = 0; RST = 0;
    // rd = x0 then consumer of x0
    instr(5'd1, 5'd10, 32'd5, 5'd0, 32'd0, 1, 32'd3, 5'd0, 1, 32'h0);
    step(); chk("rd_x0_result", ALU_RESULT, 32'd8);
    instr(5'd1, 5'd0, 32'h77, 5'd0, 32'd0, 1, 32'd1, 5'd6, 1, 32'h0);
    WB_RD_ADDRESS = 0; WB_RD_DATA = 32'h99; WB_RD_WRITE_ENABLE = 1;
    #2 chk("x0_no_stall", 32'(LOAD_USE_STALL), 32'd0);
    step(); chk("x0_reads_zero", ALU_RESULT, 32'd1);
    WB_RD_WRITE_ENABLE = 0;
    // SRA register and immediate forms
    instr(5'd8, 5'd11, 32'h8000_0000, 5'd12, 32'd4, 0, 32'd0, 5'd7, 1, 32'h0);
    step(); chk("sra_reg", ALU_RESULT, 32'hF800_0000);
    instr(5'd8, 5'd11, 32'h8000_0000, 5'd0, 32'd0, 1, 32'hFFFF_FFE1, 5'd7, 1, 32'h0);
    SHIFT_AMOUNT = 5'd4;
    step(); chk("sra_imm_shamt", ALU_RESULT, 32'hF800_0000);
    // Store: forwarded rs2 captured as store data
    instr(5'd1, 5'd0, 32'd0, 5'd7, 32'h1111, 1, 32'h8, 5'd0, 0, 32'h0);
    DATA_CACHE_STORE_IN = 2'd3;
    step(); chk("store_data_fwd", DATA_CACHE_STORE_DATA, 32'hF800_0000);
    DATA_CACHE_STORE_IN = 0;

    // Randomised traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      ALU_INSTRUCTION = 5'($urandom_range(0, 23));
      RS1_ADDRESS = 5'($urandom_range(0, 3)); RS2_ADDRESS = 5'($urandom_range(0, 3));
      RD_ADDRESS_IN = 5'($urandom_range(0, 3));
      RS1_DATA = ($urandom_range(0, 3) == 0) ? RS2_DATA : $urandom;
      RS2_DATA = $urandom; IMM_INPUT = $urandom; PC_IN = $urandom;
      SHIFT_AMOUNT = 5'($urandom_range(0, 31));
      ALU_INPUT_1_SELECT = 1'($urandom_range(0, 1)); ALU_INPUT_2_SELECT = 1'($urandom_range(0, 1));
      DATA_CACHE_LOAD_IN = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
      DATA_CACHE_STORE_IN = 2'($urandom_range(0, 3));
      WRITE_BACK_MUX_SELECT_IN = 1'($urandom_range(0, 1));
      RD_WRITE_ENABLE_IN = 1'($urandom_range(0, 1));
      WB_RD_ADDRESS = 5'($urandom_range(0, 3)); WB_RD_DATA = $urandom;
      WB_RD_WRITE_ENABLE = 1'($urandom_range(0, 1));
      STALL_EXECUTION_STAGE = ($urandom_range(0, 7) == 0);
      CLEAR_EXECUTION_STAGE = ($urandom_range(0, 15) == 0);
      RST = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    RST = 0;
    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
